// File: rtl/axicb_fifo_push_arbiter.sv
// Round-robin arbiter sharing one FIFO write port, with per-packet lock.
// Optional strict-priority class: define AXICB_FIFO_PUSH_ARB_PRIO_EN.
module axicb_fifo_push_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 2
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        srst,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ-1:0]            last,
  input  logic [N_REQ*DATA_WIDTH-1:0] data_in,
  output logic [N_REQ-1:0]            ready,
  output logic                        fifo_push,
  output logic [DATA_WIDTH-1:0]       fifo_data,
  input  logic                        fifo_full,
  output logic                        busy,
  output logic [ID_WIDTH-1:0]         grant_id
`ifdef AXICB_FIFO_PUSH_ARB_PRIO_EN
  ,
  input  logic [N_REQ-1:0]            prio
`endif
);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t              state_q, state_d;
  logic [ID_WIDTH-1:0] gnt_q, gnt_d;
  logic [ID_WIDTH-1:0] ptr_q, ptr_d;
  logic [ID_WIDTH-1:0] winner;
  logic [N_REQ-1:0]    cand;
  logic                req_g;
  logic                last_g;
  int                  best;

`ifdef AXICB_FIFO_PUSH_ARB_PRIO_EN
  assign cand = (|(req & prio)) ? (req & prio) : req;
`else
  assign cand = req;
`endif

  // Smallest rotated distance from ptr+1 wins.
  always_comb begin
    winner = '0;
    best   = N_REQ;
    for (int i = 0; i < N_REQ; i++) begin
      if (cand[i] &&
          ((i + N_REQ - int'(ptr_q) - 1) % N_REQ) < best) begin
        best   = (i + N_REQ - int'(ptr_q) - 1) % N_REQ;
        winner = ID_WIDTH'(i);
      end
    end
  end

  always_comb begin
    req_g     = 1'b0;
    last_g    = 1'b0;
    fifo_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_q == ID_WIDTH'(i)) begin
        req_g     = req[i];
        last_g    = last[i];
        fifo_data = data_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    ready     = '0;
    fifo_push = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|cand) begin
          gnt_d   = winner;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        for (int i = 0; i < N_REQ; i++) begin
          ready[i] = (gnt_q == ID_WIDTH'(i)) & ~fifo_full;
        end
        fifo_push = req_g & ~fifo_full;
        if (fifo_push && last_g) begin
          ptr_d   = gnt_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= ID_WIDTH'(N_REQ - 1);
    end else if (srst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= ID_WIDTH'(N_REQ - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign busy     = (state_q == LOCKED);
  assign grant_id = gnt_q;

endmodule

// File: tb/tb_axicb_fifo_push_arbiter.sv
// Directed bench for axicb_fifo_push_arbiter.
// Define AXICB_FIFO_PUSH_ARB_PRIO_EN to also cover the priority class.
module tb_axicb_fifo_push_arbiter;

  logic        aclk;
  logic        aresetn;
  logic        srst;
  logic [3:0]  req;
  logic [3:0]  last;
  logic [31:0] data_in;
  logic [3:0]  ready;
  logic        fifo_push;
  logic [7:0]  fifo_data;
  logic        fifo_full;
  logic        busy;
  logic [1:0]  grant_id;
`ifdef AXICB_FIFO_PUSH_ARB_PRIO_EN
  logic [3:0]  prio;
`endif

  int checks = 0;
  int errors = 0;

  axicb_fifo_push_arbiter #(
    .N_REQ(4), .DATA_WIDTH(8), .ID_WIDTH(2)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .srst(srst),
    .req(req),
    .last(last),
    .data_in(data_in),
    .ready(ready),
    .fifo_push(fifo_push),
    .fifo_data(fifo_data),
    .fifo_full(fifo_full),
    .busy(busy),
    .grant_id(grant_id)
`ifdef AXICB_FIFO_PUSH_ARB_PRIO_EN
    ,
    .prio(prio)
`endif
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  function automatic logic [7:0] dv(input int i);
    return 8'hA0 + 8'(i * 17);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic st(input logic [3:0] r, input logic [3:0] l,
                    input logic f);
    req       = r;
    last      = l;
    fifo_full = f;
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_push"}, 32'(fifo_push), 32'd0);
    chk({tag, "_ready"}, 32'(ready), 32'd0);
  endtask

  task automatic chk_lock(input string tag, input int id,
                          input logic push, input logic [3:0] rdy);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_gid"}, 32'(grant_id), 32'(id));
    chk({tag, "_push"}, 32'(fifo_push), 32'(push));
    chk({tag, "_ready"}, 32'(ready), 32'(rdy));
    if (push) chk({tag, "_data"}, 32'(fifo_data), 32'(dv(id)));
  endtask

  task automatic pkt2(input int id);
    tick; st(4'b1111, 4'b0000, 1'b0);
    chk_lock("t1_b1", id, 1'b1, 4'(1 << id));
    tick; st(4'b1111, 4'b1111, 1'b0);
    chk_lock("t1_b2", id, 1'b1, 4'(1 << id));
    tick; st(4'b1111, 4'b0000, 1'b0);
    chk_idle("t1_bub");
  endtask

  initial begin
    aresetn   = 1'b0;
    srst      = 1'b0;
    req       = '0;
    last      = '0;
    fifo_full = 1'b0;
    data_in   = {dv(3), dv(2), dv(1), dv(0)};
`ifdef AXICB_FIFO_PUSH_ARB_PRIO_EN
    prio      = '0;
`endif
    #12;
    chk_idle("rst");
    chk("rst_gid", 32'(grant_id), 32'd0);
    aresetn = 1'b1;

    // round robin over 2-beat packets
    tick; st(4'b1111, 4'b0000, 1'b0);
    chk_idle("t1_idle");
    pkt2(0);
    pkt2(1);
    pkt2(2);
    pkt2(3);
    pkt2(0);

    // lock hold: req 1 four beats while req 2 waits
    tick; st(4'b0110, 4'b0000, 1'b0);
    chk_lock("t2_b1", 1, 1'b1, 4'b0010);
    for (int b = 1; b < 4; b++) begin
      tick; st(4'b0110, (b == 3) ? 4'b0010 : 4'b0000, 1'b0);
      chk_lock("t2_bn", 1, 1'b1, 4'b0010);
    end
    tick; st(4'b0110, 4'b0000, 1'b0);
    chk_idle("t2_bub");

    // backpressure, req drop and last without req
    tick; st(4'b0100, 4'b0000, 1'b0);
    chk_lock("t3_b1", 2, 1'b1, 4'b0100);
    for (int c = 0; c < 3; c++) begin
      tick; st(4'b0100, 4'b0000, 1'b1);
      chk_lock("t3_full", 2, 1'b0, 4'b0000);
    end
    tick; st(4'b0001, 4'b0100, 1'b0);
    chk_lock("t3_drop", 2, 1'b0, 4'b0100);
    tick; st(4'b0100, 4'b0100, 1'b0);
    chk_lock("t3_last", 2, 1'b1, 4'b0100);

    // wrap: ptr=3 after requester 3, then 0 before 3
    tick; st(4'b1000, 4'b1000, 1'b0);
    chk_idle("t4_i0");
    tick; chk_lock("t4_g3a", 3, 1'b1, 4'b1000);
    tick; st(4'b1001, 4'b1001, 1'b0);
    chk_idle("t4_i1");
    tick; chk_lock("t4_g0", 0, 1'b1, 4'b0001);
    tick; chk_idle("t4_i2");
    tick; chk_lock("t4_g3b", 3, 1'b1, 4'b1000);
    tick; st(4'b0010, 4'b0010, 1'b0);
    chk_idle("t4_i3");

    // srst mid-packet must also restore ptr
    tick; chk_lock("t5_g1", 1, 1'b1, 4'b0010);
    tick; st(4'b0100, 4'b0000, 1'b0);
    chk_idle("t5_i0");
    tick; chk_lock("t5_b1", 2, 1'b1, 4'b0100);
    tick; chk_lock("t5_b2", 2, 1'b1, 4'b0100);
    srst = 1'b1;
    tick; srst = 1'b0;
    st(4'b0101, 4'b0000, 1'b0);
    chk_idle("t5_srst");
    chk("t5_srst_gid", 32'(grant_id), 32'd0);
    tick; st(4'b0101, 4'b0101, 1'b0);
    chk_lock("t5_g0", 0, 1'b1, 4'b0001);
    tick; chk_idle("t5_i1");
    tick; chk_lock("t5_g2", 2, 1'b1, 4'b0100);
    tick; st(4'b0000, 4'b0000, 1'b0);
    chk_idle("t5_i2");

`ifdef AXICB_FIFO_PUSH_ARB_PRIO_EN
    prio = 4'b0100;
    st(4'b1111, 4'b1111, 1'b0);
    tick; chk_lock("t6_p0", 2, 1'b1, 4'b0100);
    tick; chk_idle("t6_i0");
    tick; chk_lock("t6_p1", 2, 1'b1, 4'b0100);
    tick; prio = 4'b0000;
    #1 chk_idle("t6_i1");
    tick; chk_lock("t6_r3", 3, 1'b1, 4'b1000);
    tick; chk_idle("t6_i2");
    tick; chk_lock("t6_r0", 0, 1'b1, 4'b0001);
    tick; chk_idle("t6_i3");
    tick; chk_lock("t6_r1", 1, 1'b1, 4'b0010);
    tick; chk_idle("t6_i4");
    tick; chk_lock("t6_r2", 2, 1'b1, 4'b0100);
    tick;
`endif

    // asynchronous reset mid-packet
    st(4'b0001, 4'b0000, 1'b0);
    chk_idle("t7_i0");
    tick; chk_lock("t7_g0", 0, 1'b1, 4'b0001);
    aresetn = 1'b0;
    #1;
    chk_idle("t7_arst");
    chk("t7_arst_gid", 32'(grant_id), 32'd0);
    aresetn = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axicb_fifo_push_arbiter.md
Name: axicb_fifo_push_arbiter

Overview:
- Shares one single-clock FIFO write port (push/full/data_in) between N_REQ requesters.
- Round-robin arbitration with a packet lock: a granted requester keeps the FIFO until its beat flagged last is pushed.
- Sits in the AXI crossbar between the per-slave-port request streams and a shared response/request FIFO.
- Optional strict-priority class, compiled in by macro.

Parameters:
- N_REQ, 4: number of requesters; range 2..16.
- DATA_WIDTH, 8: beat width per requester and to the FIFO.
- ID_WIDTH, 2: width of grant_id; must satisfy 2**ID_WIDTH >= N_REQ.

Ports:
- aclk  input  1  clock; all logic on rising edge.
- aresetn  input  1  asynchronous active-low reset.
- srst  input  1  synchronous reset; same effect as aresetn, applied on the clock edge.
- req  input  N_REQ  per-requester beat valid.
- last  input  N_REQ  per-requester end-of-packet flag; qualified by req.
- data_in  input  N_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- ready  output  N_REQ  per-requester beat accepted when req[i] & ready[i].
- fifo_push  output  1  FIFO push strobe.
- fifo_data  output  DATA_WIDTH  FIFO write data.
- fifo_full  input  1  FIFO full flag.
- busy  output  1  arbiter is in the LOCKED state.
- grant_id  output  ID_WIDTH  index of the current owner; valid while busy=1.

Behaviour:
- Reset values (aresetn=0, or srst=1 at a clock edge):
  - ready=0, fifo_push=0, busy=0, grant_id=0, state=IDLE.
  - Round-robin pointer ptr = N_REQ-1, so requester 0 wins the first arbitration.
- State machine has two states, IDLE and LOCKED.
  - IDLE: ready=0, fifo_push=0. If |req=1, the winner is the first i with req[i]=1, scanning from ptr+1 upward modulo N_REQ. The next edge registers grant_id=winner and moves to LOCKED. If no request, stay in IDLE.
  - LOCKED (g = grant_id): ready[g] = ~fifo_full; all other ready bits are 0. fifo_push = req[g] & ~fifo_full. fifo_data = data_in slice g, driven combinationally.
  - LOCKED exit: on a push with last[g]=1, the next edge sets ptr=g and returns to IDLE.
- Latency:
  - One cycle from req assertion in IDLE to the first possible accepted beat.
  - One idle bubble cycle between packets; peak throughput is packet_len/(packet_len+1).
- fifo_full=1 in LOCKED: no push, ready[g]=0, data is held by the requester, lock is retained indefinitely.
- req[g] dropping mid-packet: lock is retained and no push occurs; other requesters stay blocked until g completes.
- last without req is ignored.
- Single-beat packet (req and last together on the first beat): one push, then back to IDLE.
- Wrap-around: when ptr=N_REQ-1, scanning starts at requester 0. A requester with a continuous stream of packets gets at most one packet per arbitration round while others request.
- srst or aresetn mid-packet: the packet is abandoned and the block returns to the reset values. The FIFO's own flush is the owner's responsibility.
- fifo_push is never asserted when fifo_full=1. Exactly one ready bit is high at most.

Optional Feature:
- Macro AXICB_FIFO_PUSH_ARB_PRIO_EN.
- When defined:
  - Adds input port prio, width N_REQ.
  - In IDLE, if any req[i]&prio[i] is set, round-robin runs only over that masked set.
  - Otherwise round-robin runs over all of req.
  - ptr is shared between both classes.
  - Locking is unchanged: priority never pre-empts a locked packet.
- When undefined: no prio port; pure round-robin as above.

Test Plan:
1. Reset, req=4'b1111, each requester sending a 2-beat packet with last on beat 2 -> grant_id sequence 0,1,2,3,0. Each packet is 2 pushes followed by 1 busy=0 cycle. fifo_data equals the granted slice.
2. Lock hold: requester 1 sends a 4-beat packet while req[2]=1 throughout -> grant_id stays 1 for 4 pushes. ready[2]=0 the whole time. Requester 2 is granted on the cycle after busy drops.
3. Backpressure: during a packet, fifo_full=1 for 3 cycles -> fifo_push=0 and ready=0 for those 3 cycles, grant_id unchanged. The beat is pushed on the first cycle with fifo_full=0.
4. Wrap and fairness: ptr=3 (requester 3 just finished), req=4'b1001 -> requester 0 granted next, then requester 3.
5. Mid-packet srst after beat 2 of 4 -> next cycle busy=0, ready=0, fifo_push=0. After release, req=4'b0100 grants requester 2 (ptr reset to 3).
6. With AXICB_FIFO_PUSH_ARB_PRIO_EN: req=4'b1111, prio=4'b0100, single-beat packets -> requester 2 granted every arbitration while prio[2]=1. After prio=0, grant order resumes 3,0,1,2.
